// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the multi-cycle divide sequencer:
//   - div_state_e : sequencer state encoding (IDLE, RUN, FIX)
//   - DIV_WIDTH   : default operand/result width
//   - DIV_CNT_W   : width of the iteration counter, clog2(DIV_WIDTH)
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational non-restoring division iteration.
// Ports:
//   aq      in  2*WIDTH+1  current {A,Q}; A is WIDTH+1 bits (two's complement)
//   m       in  WIDTH      divisor magnitude M
//   aq_next out 2*WIDTH+1  {A,Q} after shift and add/subtract
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [2*WIDTH:0] aq,
    input  logic [WIDTH-1:0] m,
    output logic [2*WIDTH:0] aq_next
);

    logic [2*WIDTH:0] shifted_s;
    logic [WIDTH:0]   a_shift_s;
    logic [WIDTH:0]   m_ext_s;
    logic [WIDTH:0]   a_new_s;
    logic             sign_s;

    // Shift {A,Q} left, then add or subtract M based on the pre-shift sign of A.
    // The pre-shift sign is used because the shifted value may wrap, while the
    // post-add/subtract result always fits back into WIDTH+1 bits.
    always_comb begin
        sign_s    = aq[2*WIDTH];
        shifted_s = {aq[2*WIDTH-1:0], 1'b0};
        a_shift_s = shifted_s[2*WIDTH:WIDTH];
        m_ext_s   = {1'b0, m};
        if (sign_s) begin
            a_new_s = a_shift_s + m_ext_s;
        end else begin
            a_new_s = a_shift_s + (~m_ext_s) + {{WIDTH{1'b0}}, 1'b1};
        end
        aq_next = {a_new_s, shifted_s[WIDTH-1:1], ~a_new_s[WIDTH]};
    end

endmodule

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
// Multi-cycle non-restoring integer divider: one iteration per clock, then a
// remainder-correction cycle. Normal latency WIDTH+1 cycles after acceptance,
// divide-by-zero completes in the cycle after acceptance.
// Optional feature macro: DIV_SIGNED_EN (two's-complement operands, truncating
// division). Undefined -> unsigned only.
// Ports:
//   clock     in   rising-edge clock
//   clear     in   asynchronous active-high reset
//   start     in   divide request, sampled only while idle
//   dividend  in   numerator, captured on the accepting edge
//   divisor   in   denominator, captured on the accepting edge
//   busy      out  operation in progress
//   done      out  one-cycle completion pulse
//   quotient  out  quotient, held until the next completion
//   remainder out  remainder, held until the next completion
//   div_zero  out  divisor was zero, held like the results
// -----------------------------------------------------------------------------
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
`endif

    div_state_e       state_r;
    div_state_e       state_next_s;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH:0]   acc_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dsr_r;
    logic [WIDTH-1:0] dvd_raw_r;
    logic             zero_r;
`ifdef DIV_SIGNED_EN
    logic             neg_quo_r;
    logic             neg_rem_r;
    logic             neg_quo_s;
    logic             neg_rem_s;
`endif

    logic             busy_r;
    logic             done_r;
    logic             div_zero_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    logic [2*WIDTH:0] step_next_s;
    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dsr_mag_s;
    logic [WIDTH-1:0] rem_fix_s;
    logic [WIDTH-1:0] quo_res_s;
    logic [WIDTH-1:0] rem_res_s;

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .aq      ({acc_r, quo_r}),
        .m       (dsr_r),
        .aq_next (step_next_s)
    );

    // Operand conditioning at capture: magnitudes and result signs when signed.
    always_comb begin
`ifdef DIV_SIGNED_EN
        neg_rem_s = dividend[WIDTH-1];
        neg_quo_s = dividend[WIDTH-1] ^ divisor[WIDTH-1];
        if (dividend[WIDTH-1]) begin
            dvd_mag_s = ~dividend + ONE_W;
        end else begin
            dvd_mag_s = dividend;
        end
        if (divisor[WIDTH-1]) begin
            dsr_mag_s = ~divisor + ONE_W;
        end else begin
            dsr_mag_s = divisor;
        end
`else
        dvd_mag_s = dividend;
        dsr_mag_s = divisor;
`endif
    end

    // Final correction: restore a negative remainder, then apply result signs.
    // Only the low WIDTH bits of A are kept, so the add can be done at WIDTH.
    always_comb begin
        if (acc_r[WIDTH]) begin
            rem_fix_s = acc_r[WIDTH-1:0] + dsr_r;
        end else begin
            rem_fix_s = acc_r[WIDTH-1:0];
        end
`ifdef DIV_SIGNED_EN
        if (neg_quo_r) begin
            quo_res_s = ~quo_r + ONE_W;
        end else begin
            quo_res_s = quo_r;
        end
        if (neg_rem_r) begin
            rem_res_s = ~rem_fix_s + ONE_W;
        end else begin
            rem_res_s = rem_fix_s;
        end
`else
        quo_res_s = quo_r;
        rem_res_s = rem_fix_s;
`endif
    end

    // State register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: a zero divisor skips the iterations entirely.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (divisor == ZERO_W) begin
                        state_next_s = FIX;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == LAST_CNT) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = RUN;
                end
            end
            FIX:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, counter and result registers.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count_r     <= {CNT_W{1'b0}};
            acc_r       <= {(WIDTH+1){1'b0}};
            quo_r       <= ZERO_W;
            dsr_r       <= ZERO_W;
            dvd_raw_r   <= ZERO_W;
            zero_r      <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_r   <= 1'b0;
            neg_rem_r   <= 1'b0;
`endif
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            div_zero_r  <= 1'b0;
            quotient_r  <= ZERO_W;
            remainder_r <= ZERO_W;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r     <= {(WIDTH+1){1'b0}};
                        count_r   <= {CNT_W{1'b0}};
                        quo_r     <= dvd_mag_s;
                        dsr_r     <= dsr_mag_s;
                        dvd_raw_r <= dividend;
                        zero_r    <= (divisor == ZERO_W);
`ifdef DIV_SIGNED_EN
                        neg_quo_r <= neg_quo_s;
                        neg_rem_r <= neg_rem_s;
`endif
                        busy_r    <= 1'b1;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                RUN: begin
                    {acc_r, quo_r} <= step_next_s;
                    count_r        <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                FIX: begin
                    if (zero_r) begin
                        quotient_r  <= ONES_W;
                        remainder_r <= dvd_raw_r;
                        div_zero_r  <= 1'b1;
                    end else begin
                        quotient_r  <= quo_res_s;
                        remainder_r <= rem_res_s;
                        div_zero_r  <= 1'b0;
                    end
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_sequencer
// Directed self-checking bench for div_sequencer at WIDTH = 32.
// -----------------------------------------------------------------------------
module tb_div_sequencer;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int checks;
    int errors;
    int lat;
    int bcnt;

    div_sequencer #(
        .WIDTH     (32)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one divide (caller is #1 after a rising edge, DUT idle) and wait
    // for done. lat = cycles from the accept edge to done (-1 on timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int l, output int bc);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clock); #1;
        start = 1'b0;
        l  = -1;
        bc = 0;
        for (int j = 0; j < 100; j++) begin
            if (busy) bc++;
            if (done) begin
                l = j;
                break;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; dividend = 32'd0; divisor = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        checks += 5;
        if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        if (quotient !== 32'd0)   begin errors++; $display("FAIL reset_q: got %h expected 0", quotient); end
        if (remainder !== 32'd0)  begin errors++; $display("FAIL reset_r: got %h expected 0", remainder); end
        if (div_zero !== 1'b0)    begin errors++; $display("FAIL reset_dz: got %b expected 0", div_zero); end
        clear = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        run_op(32'd100, 32'd7, lat, bcnt);
        checks += 5;
        if (lat !== 33)            begin errors++; $display("FAIL basic_latency: got %0d expected 33", lat); end
        if (bcnt !== 33)           begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 33", bcnt); end
        if (quotient !== 32'd14)   begin errors++; $display("FAIL basic_q: got %0d expected 14", quotient); end
        if (remainder !== 32'd2)   begin errors++; $display("FAIL basic_r: got %0d expected 2", remainder); end
        if (div_zero !== 1'b0)     begin errors++; $display("FAIL basic_dz: got %b expected 0", div_zero); end
        @(posedge clock); #1;
        checks += 2;
        if (done !== 1'b0)         begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        if (quotient !== 32'd14)   begin errors++; $display("FAIL basic_q_hold: got %0d expected 14", quotient); end
    endtask

    task automatic test_extremes();
        run_op(32'hFFFF_FFFF, 32'd1, lat, bcnt);
        checks += 3;
        if (lat !== 33)                 begin errors++; $display("FAIL ext1_latency: got %0d expected 33", lat); end
        if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ext1_q: got %h expected ffffffff", quotient); end
        if (remainder !== 32'd0)        begin errors++; $display("FAIL ext1_r: got %h expected 0", remainder); end
        @(posedge clock); #1;
        run_op(32'd5, 32'hFFFF_FFFF, lat, bcnt);
        checks += 2;
`ifdef DIV_SIGNED_EN
        if (quotient !== 32'hFFFF_FFFB) begin errors++; $display("FAIL ext2_q: got %h expected fffffffb", quotient); end
        if (remainder !== 32'd0)        begin errors++; $display("FAIL ext2_r: got %h expected 0", remainder); end
`else
        if (quotient !== 32'd0)         begin errors++; $display("FAIL ext2_q: got %h expected 0", quotient); end
        if (remainder !== 32'd5)        begin errors++; $display("FAIL ext2_r: got %h expected 5", remainder); end
`endif
        @(posedge clock); #1;
    endtask

    task automatic test_div_zero();
        run_op(32'd5, 32'd0, lat, bcnt);
        checks += 5;
        if (lat !== 1)                  begin errors++; $display("FAIL dz_latency: got %0d expected 1", lat); end
        if (bcnt !== 1)                 begin errors++; $display("FAIL dz_busy_cycles: got %0d expected 1", bcnt); end
        if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_q: got %h expected ffffffff", quotient); end
        if (remainder !== 32'd5)        begin errors++; $display("FAIL dz_r: got %h expected 5", remainder); end
        if (div_zero !== 1'b1)          begin errors++; $display("FAIL dz_flag: got %b expected 1", div_zero); end
        repeat (3) @(posedge clock);
        #1;
        checks += 3;
        if (done !== 1'b0)              begin errors++; $display("FAIL dz_done_pulse: got %b expected 0", done); end
        if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_q_hold: got %h expected ffffffff", quotient); end
        if (div_zero !== 1'b1)          begin errors++; $display("FAIL dz_flag_hold: got %b expected 1", div_zero); end
        run_op(32'd100, 32'd7, lat, bcnt);
        checks += 2;
        if (div_zero !== 1'b0)          begin errors++; $display("FAIL dz_flag_cleared: got %b expected 0", div_zero); end
        if (quotient !== 32'd14)        begin errors++; $display("FAIL dz_next_q: got %0d expected 14", quotient); end
        @(posedge clock); #1;
    endtask

    task automatic test_sign();
        run_op(32'hFFFF_FFF9, 32'd2, lat, bcnt);
        checks += 2;
`ifdef DIV_SIGNED_EN
        if (quotient !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sign_q: got %h expected fffffffd", quotient); end
        if (remainder !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sign_r: got %h expected ffffffff", remainder); end
`else
        if (quotient !== 32'h7FFF_FFFC) begin errors++; $display("FAIL sign_q: got %h expected 7ffffffc", quotient); end
        if (remainder !== 32'd1)        begin errors++; $display("FAIL sign_r: got %h expected 1", remainder); end
`endif
        @(posedge clock); #1;
    endtask

    task automatic test_start_while_busy();
        int l;
        start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
        @(posedge clock); #1;
        start = 1'b0;
        l = -1;
        for (int j = 0; j < 100; j++) begin
            if (j == 5) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd4;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                l = j;
                break;
            end
            @(posedge clock); #1;
        end
        start = 1'b0;
        checks += 3;
        if (l !== 33)              begin errors++; $display("FAIL busy_start_latency: got %0d expected 33", l); end
        if (quotient !== 32'd100)  begin errors++; $display("FAIL busy_start_q: got %0d expected 100", quotient); end
        if (remainder !== 32'd0)   begin errors++; $display("FAIL busy_start_r: got %0d expected 0", remainder); end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        run_op(32'd100, 32'd7, lat, bcnt);
        // Still in the done cycle: the next request is accepted immediately.
        run_op(32'd200, 32'd9, lat, bcnt);
        checks += 3;
        if (lat !== 33)            begin errors++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
        if (quotient !== 32'd22)   begin errors++; $display("FAIL b2b_q: got %0d expected 22", quotient); end
        if (remainder !== 32'd2)   begin errors++; $display("FAIL b2b_r: got %0d expected 2", remainder); end
        @(posedge clock); #1;
    endtask

    task automatic test_clear_mid_op();
        int ndone;
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clock); #1;
        end
        clear = 1'b1;
        #1;
        checks += 5;
        if (busy !== 1'b0)        begin errors++; $display("FAIL clear_busy: got %b expected 0", busy); end
        if (done !== 1'b0)        begin errors++; $display("FAIL clear_done: got %b expected 0", done); end
        if (quotient !== 32'd0)   begin errors++; $display("FAIL clear_q: got %h expected 0", quotient); end
        if (remainder !== 32'd0)  begin errors++; $display("FAIL clear_r: got %h expected 0", remainder); end
        if (div_zero !== 1'b0)    begin errors++; $display("FAIL clear_dz: got %b expected 0", div_zero); end
        @(posedge clock); #1;
        clear = 1'b0;
        ndone = 0;
        for (int j = 0; j < 40; j++) begin
            if (done || busy) ndone++;
            @(posedge clock); #1;
        end
        checks += 1;
        if (ndone !== 0)          begin errors++; $display("FAIL clear_no_done: got %0d active cycles expected 0", ndone); end
        run_op(32'd100, 32'd7, lat, bcnt);
        checks += 3;
        if (lat !== 33)           begin errors++; $display("FAIL clear_next_latency: got %0d expected 33", lat); end
        if (quotient !== 32'd14)  begin errors++; $display("FAIL clear_next_q: got %0d expected 14", quotient); end
        if (remainder !== 32'd2)  begin errors++; $display("FAIL clear_next_r: got %0d expected 2", remainder); end
        @(posedge clock); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_sign();
        test_start_while_busy();
        test_back_to_back();
        test_clear_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
